// File: rtl/boron_pkg.sv
// boron_pkg: shared BORON tables, constants, FSM states and round/key helper functions.
package boron_pkg;
  localparam int NUM_ROUNDS = 25;
  localparam int KEY_ROT = 13;
  localparam int SHUF_ROT = 4;
  localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS - 1);
  localparam logic [63:0] SBOX = 64'h6358F02DAC971B4E;
  localparam logic [63:0] INV_SBOX = 64'hB086275C4FD1E93A;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;
  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [4:0] rc);
    logic [127:0] t;
    t = {k[127-KEY_ROT:0], k[127:128-KEY_ROT]};
    t[3:0] = sbox(t[3:0]);
    t[63:59] = t[63:59] ^ rc;
    return t;
  endfunction
  function automatic logic [15:0] rotr16(input logic [15:0] w, input int n);
    return (w >> n) | (w << (16 - n));
  endfunction
  function automatic logic [63:0] inv_xor(input logic [63:0] s);
    logic [15:0] w3, w2, w1, w0;
    w3 = s[63:48];
    w2 = s[47:32] ^ w3;
    w1 = s[31:16] ^ w2;
    w0 = s[15:0] ^ w1;
    return {w3, w2, w1, w0};
  endfunction
  function automatic logic [63:0] inv_perm(input logic [63:0] s);
    return {rotr16(s[63:48], 9), rotr16(s[47:32], 7), rotr16(s[31:16], 4), rotr16(s[15:0], 1)};
  endfunction
  function automatic logic [63:0] inv_shuffle(input logic [63:0] s);
    return {rotr16(s[63:48], SHUF_ROT), rotr16(s[47:32], SHUF_ROT),
            rotr16(s[31:16], SHUF_ROT), rotr16(s[15:0], SHUF_ROT)};
  endfunction
  function automatic logic [63:0] inv_sub(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_sbox(s[4*i +: 4]);
    return r;
  endfunction
  function automatic logic [63:0] inv_round(input logic [63:0] s);
    return inv_sub(inv_shuffle(inv_perm(inv_xor(s))));
  endfunction
endpackage

// File: rtl/boron_decrypt_key_inv.sv
// boron_key_inv: one backward step of the BORON key schedule (undo counter XOR, low-nibble S-box, rotate).
module boron_key_inv
  import boron_pkg::*;
(
  input  logic [127:0] key,
  input  logic [4:0]   rc,
  output logic [127:0] key_prev
);
  logic [127:0] t;
  always_comb begin
    t = key;
    t[63:59] = t[63:59] ^ rc;
    t[3:0] = inv_sbox(t[3:0]);
    key_prev = {t[KEY_ROT-1:0], t[127:KEY_ROT]};
  end
endmodule

// File: rtl/boron_decrypt.sv
// boron_decrypt: iterative BORON decryption, key expanded forward then unwound per round.
// Defining BORON_KEY_CACHE_EN remembers the last key's K25 so a repeated key skips expansion.
module boron_decrypt
  import boron_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  cipher_txt,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  plain_txt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   round_cnt
);
  state_t st;
  logic [127:0] key_reg, key_next, key_prev, hit_key;
  logic [63:0] state_reg, round_out;
  logic accept, hit, kx_last;
  boron_key_inv u_key_inv (.key(key_reg), .rc(round_cnt), .key_prev(key_prev));
  assign key_next = key_fwd(key_reg, round_cnt);
  assign round_out = inv_round(state_reg) ^ key_prev[63:0];
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign accept = in_valid && in_ready;
  assign kx_last = st == KEYEXP && round_cnt == LAST_RC;
`ifdef BORON_KEY_CACHE_EN
  logic [127:0] cached_key, k25;
  logic cache_vld;
  assign hit = cache_vld && key_in == cached_key;
  assign hit_key = k25;
  // the cache is invalid from a missing accept until that key's expansion completes
  always_ff @(posedge clk) begin
    if (reset) cache_vld <= 1'b0;
    else if (accept && !hit) begin
      cached_key <= key_in;
      cache_vld <= 1'b0;
    end else if (kx_last) begin
      k25 <= key_next;
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_key = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      key_reg <= '0;
      state_reg <= '0;
      plain_txt <= '0;
      round_cnt <= '0;
    end else begin
      unique case (st)
        IDLE: if (accept) begin
          st <= hit ? ROUND : KEYEXP;
          key_reg <= hit ? hit_key : key_in;
          state_reg <= hit ? cipher_txt ^ hit_key[63:0] : cipher_txt;
          round_cnt <= hit ? LAST_RC : 5'd0;
        end
        KEYEXP: begin
          key_reg <= key_next;
          if (kx_last) begin
            st <= ROUND;
            state_reg <= state_reg ^ key_next[63:0];
          end else round_cnt <= round_cnt + 5'd1;
        end
        ROUND: begin
          state_reg <= round_out;
          key_reg <= key_prev;
          if (round_cnt == 5'd0) begin
            st <= DONE;
            plain_txt <= round_out;
          end else round_cnt <= round_cnt - 5'd1;
        end
        DONE: if (out_ready) st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boron_decrypt.sv
// tb_boron_decrypt: forward BORON model encrypts random blocks; the decryptor must recover them with exact timing.
module tb_boron_decrypt;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [63:0] cipher_txt = '0;
  logic [127:0] key_in = '0;
  logic in_ready, out_valid;
  logic [63:0] plain_txt;
  logic [4:0] round_cnt;
  int checks = 0, errors = 0;
  bit m_busy = 0, m_hit = 0, cv = 0;
  int m_n = 0, m_l = 51;
  logic [63:0] m_p = '0, cur_p = '0;
  logic [127:0] ck = '0;
  localparam logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                     4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  boron_decrypt dut (.clk(clk), .reset(reset), .cipher_txt(cipher_txt), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .plain_txt(plain_txt), .out_valid(out_valid),
    .out_ready(out_ready), .round_cnt(round_cnt));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    return (w << n) | (w >> (16 - n));
  endfunction
  function automatic logic [63:0] sub(input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = SB[s[4*i +: 4]];
    return r;
  endfunction
  function automatic logic [63:0] fwd_round(input logic [63:0] s);
    logic [63:0] a, b;
    a = sub(s);
    a = {rotl16(a[63:48], 4), rotl16(a[47:32], 4), rotl16(a[31:16], 4), rotl16(a[15:0], 4)};
    b = {rotl16(a[63:48], 9), rotl16(a[47:32], 7), rotl16(a[31:16], 4), rotl16(a[15:0], 1)};
    return {b[63:48], b[47:32] ^ b[63:48], b[31:16] ^ b[47:32], b[15:0] ^ b[31:16]};
  endfunction
  function automatic logic [127:0] kfwd(input logic [127:0] k, input int r);
    logic [127:0] t;
    t = {k[114:0], k[127:115]};
    t[3:0] = SB[t[3:0]];
    t[63:59] = t[63:59] ^ 5'(r);
    return t;
  endfunction
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [127:0] k);
    logic [63:0] s;
    logic [127:0] kk;
    s = p;
    kk = k;
    for (int r = 0; r < 25; r++) begin
      s = fwd_round(s ^ kk[63:0]);
      kk = kfwd(kk, r);
    end
    return s ^ kk[63:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // expected outputs follow only from cycles elapsed since accept and the latency class
  task automatic compare();
    bit dn;
    int erc;
    dn = m_busy && m_n >= m_l - 1;
    erc = (m_busy && !dn) ? ((!m_hit && m_n < 25) ? m_n : m_l - 2 - m_n) : 0;
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, dn);
    chk("round_cnt", round_cnt, erc);
    if (dn) chk("plain_txt", plain_txt, m_p);
  endtask

  task automatic model_step();
    if (reset) begin
      m_busy = 0;
      cv = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1;
        m_n = 0;
        m_p = cur_p;
`ifdef BORON_KEY_CACHE_EN
        m_hit = cv && key_in == ck;
        if (!m_hit) begin
          ck = key_in;
          cv = 1;
        end
`else
        m_hit = 0;
`endif
        m_l = m_hit ? 26 : 51;
      end
    end else if (m_n >= m_l - 1 && out_ready) m_busy = 0;
    else m_n++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (!reset) compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // lat counts rising edges with the accept edge as 1, ending at the edge that raises out_valid
  task automatic send(input logic [63:0] p, input logic [127:0] k, input int hold, output int lat);
    cur_p = p;
    key_in = k;
    cipher_txt = enc(p, k);
    in_valid = 1;
    out_ready = (hold == 0);
    tick();
    lat = 1;
    in_valid = 0;
    while (!out_valid && lat < 60) begin
      if (lat < 20) begin
        in_valid = 1'($urandom);
        cipher_txt = {$urandom, $urandom};
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else in_valid = 0;
      tick();
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, m_l);
    chk("result", plain_txt, p);
    repeat (hold) begin
      tick();
      chk("hold_plain", plain_txt, p);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    int lat, w;
    logic [127:0] k;
    repeat (3) tick();
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_plain", plain_txt, 0);
    chk("rst_round_cnt", round_cnt, 0);
    chk("pin_round0", fwd_round(64'h0), 64'hDDDD_AAAA_9999_3333);
    chk("pin_kfwd0", kfwd(128'h0, 1), 128'h0000_0000_0000_0000_0800_0000_0000_000E);
    chk("pin_kfwd1", kfwd(128'h1, 0), 128'h200E);
    send(64'h0, 128'h0, 0, lat);
    chk("zero_lat", lat, 51);
    send('1, '1, 0, lat);
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 10, lat);
    k = {$urandom, $urandom, $urandom, $urandom};
    cur_p = {$urandom, $urandom};
    key_in = k;
    cipher_txt = enc(cur_p, k);
    in_valid = 1;
    tick();
    in_valid = 0;
    w = 0;
    while (!(round_cnt == 5'd12 && m_n >= (m_hit ? 0 : 25)) && w < 60) begin
      tick();
      w++;
    end
    chk("reach_round12", w < 60, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_round_cnt", round_cnt, 0);
    repeat (3) tick();
    send(64'h0123_4567_89AB_CDEF, k, 0, lat);
`ifdef BORON_KEY_CACHE_EN
    k = {$urandom, $urandom, $urandom, $urandom};
    send({$urandom, $urandom}, k, 0, lat);
    chk("cache_miss_lat", lat, 51);
    send({$urandom, $urandom}, k, 0, lat);
    chk("cache_hit_lat", lat, 26);
    send({$urandom, $urandom}, k ^ 128'h1, 0, lat);
    chk("cache_new_key_lat", lat, 51);
`endif
    for (int i = 0; i < 1000; i++)
      send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, lat);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/boron_decrypt.md
BORON_DECRYPT -- requirements
Module: boron_decrypt

Interface
REQ-001 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 SHALL provide `clk  input  1  rising-edge clock`.
REQ-003 SHALL provide `reset  input  1  synchronous active-high reset`.
REQ-004 SHALL provide `cipher_txt  input  64  ciphertext block, sampled on accept`.
REQ-005 SHALL provide `key_in  input  128  master key, sampled on accept`.
REQ-006 SHALL provide `in_valid  input  1  request valid`.
REQ-007 SHALL provide `in_ready  output  1  high only in IDLE`.
REQ-008 SHALL provide `plain_txt  output  64  recovered plaintext, stable while out_valid`.
REQ-009 SHALL provide `out_valid  output  1  result valid`.
REQ-010 SHALL provide `out_ready  input  1  consumer ready`.
REQ-011 SHALL provide `round_cnt  output  5  current round index`.

Function
REQ-012 SHALL invert boron_top for the same key and the same S-box table (25 rounds, final whitening with K25[63:0]).
REQ-013 SHALL implement the states IDLE, KEYEXP, ROUND and DONE.
REQ-014 SHALL move from IDLE to KEYEXP on accept, defined as in_valid && in_ready.
REQ-015 SHALL, on accept, latch key_in into key_reg, set round_cnt=0 and latch cipher_txt into state_reg.
REQ-016 SHALL, in KEYEXP, apply the forward key update once per cycle for 25 cycles (round_cnt 0..24), using the same counter XOR as encryption; the cycle at round_cnt=24 moves the FSM to ROUND.
REQ-017 SHALL, on entry to ROUND, set state_reg = state_reg ^ key_reg[63:0] (K25 whitening) and set round_cnt=24.
REQ-018 SHALL, in each ROUND cycle, compute state_reg <= invSbox(invShuffle(invPerm(invXor(state_reg)))) ^ RK, then step key_reg back one round via boron_key_inv, then decrement round_cnt.
REQ-019 SHALL take RK for round r from key_reg after the inverse update for round r, i.e. the encryption round-r key.
REQ-020 SHALL define each inverse operation as the exact inverse of the corresponding encryption block:
- invXor inverts boron_xor;
- invPerm inverts round_p rotations;
- invShuffle rotates each 16-bit word right by 4;
- invSbox is the inverse 4-bit table.
REQ-021 SHALL leave ROUND after the round_cnt=0 cycle and enter DONE with plain_txt=state_reg and out_valid=1.
REQ-022 SHALL produce out_valid exactly 51 cycles after the accept edge (1 load + 25 KEYEXP + 25 ROUND) when cache is disabled or missed.
REQ-023 SHALL hold plain_txt and out_valid stable in DONE until out_valid && out_ready, then return to IDLE the next cycle.
REQ-024 SHALL ignore in_valid outside IDLE; an accept cannot occur in the same cycle as the DONE handshake.
REQ-025 SHALL drive round_cnt as 0 in IDLE and DONE.

Reset
REQ-026 SHALL, on reset, set state to IDLE, in_ready=1, out_valid=0, plain_txt=0, round_cnt=0 and key_reg=0, and clear the cache valid flag.
REQ-027 SHALL let reset asserted mid-KEYEXP or mid-ROUND abort the operation with no output produced; the next cycle is IDLE.

Configuration
REQ-028 SHALL, when macro BORON_KEY_CACHE_EN is defined, hold cached_key (128) and the K25 register (128) plus a valid flag.
REQ-029 SHALL, with BORON_KEY_CACHE_EN defined, skip KEYEXP when key_in on accept equals cached_key and the flag is valid, going straight to ROUND with key_reg=K25; latency is then 26 cycles.
REQ-030 SHALL, with BORON_KEY_CACHE_EN defined, update the cache at the end of KEYEXP.
REQ-031 SHALL, when BORON_KEY_CACHE_EN is undefined, omit all cache logic and always run KEYEXP.

Structure
REQ-032 SHALL place in shared package boron_pkg:
- the forward and inverse S-box tables;
- the constants NUM_ROUNDS=25, KEY_ROT=13 and SHUF_ROT=4;
- the FSM state enum.
REQ-033 SHALL implement the inverse key step (counter XOR, inverse S-box on low nibble, rotate right 13) in the sub-module boron_key_inv; the forward step reuses the existing key logic functions.

Verification
REQ-034 SHALL check a zero vector: key=0, cipher=boron_top(P=0, K=0), expecting plain_txt=64'h0 with out_valid at cycle 51.
REQ-035 SHALL check an all-ones round trip: key=128'hFFFF..FF, cipher=boron_top(P=64'hFFFF_FFFF_FFFF_FFFF), expecting 64'hFFFF_FFFF_FFFF_FFFF.
REQ-036 SHALL check backpressure: out_ready=0 for 10 cycles after out_valid, expecting plain_txt to hold, in_ready=0, and return to IDLE one cycle after out_ready=1.
REQ-037 SHALL check reset at round_cnt=12 in ROUND, expecting next-cycle IDLE, out_valid=0 and a subsequent block (P=64'h0123_4567_89AB_CDEF) to decrypt correctly.
REQ-038 SHALL check the cache (BORON_KEY_CACHE_EN only): two blocks with the same key, expecting the second out_valid at 26 cycles; a third block with a changed key expects 51.
REQ-039 SHALL run 1000 random (P, K) pairs through boron_top then boron_decrypt, expecting plain_txt == P every time.
